// File: rtl/crc8_pkg.sv
// Shared CRC-8 definitions: default polynomial, bytewise update function, checker FSM states.
package crc8_pkg;

    localparam logic [7:0] CRC8_POLY_DEFAULT = 8'h07;
    localparam logic [15:0] LEN_MAX = 16'hFFFF;

    typedef enum logic {
        IDLE,
        BODY
    } crc8_chk_state_t;

    // MSB-first, non-reflected update over one byte.
    function automatic logic [7:0] crc8_next(input logic [7:0] crc,
                                             input logic [7:0] data,
                                             input logic [7:0] poly);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ poly) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == LEN_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/crc8_checker_if.sv
// Byte stream in / payload stream and frame status out for crc8_checker.
// Optional err_count_o is present when CRC8_CHECKER_ERR_COUNT_EN is defined.
interface crc8_checker_if;
    logic [7:0]  data_i;
    logic        data_valid_i;
    logic        data_last_i;
    logic [7:0]  data_o;
    logic        data_valid_o;
    logic        data_last_o;
    logic        frame_done_o;
    logic        crc_ok_o;
    logic        crc_err_o;
    logic [15:0] length_o;
`ifdef CRC8_CHECKER_ERR_COUNT_EN
    logic [15:0] err_count_o;
`endif

    modport master (
`ifdef CRC8_CHECKER_ERR_COUNT_EN
        input  err_count_o,
`endif
        output data_i, data_valid_i, data_last_i,
        input  data_o, data_valid_o, data_last_o, frame_done_o,
        input  crc_ok_o, crc_err_o, length_o
    );

    modport slave (
`ifdef CRC8_CHECKER_ERR_COUNT_EN
        output err_count_o,
`endif
        input  data_i, data_valid_i, data_last_i,
        output data_o, data_valid_o, data_last_o, frame_done_o,
        output crc_ok_o, crc_err_o, length_o
    );
endinterface

// File: rtl/crc8_step.sv
// Combinational single-byte CRC-8 update: xor the byte in, then eight shift/conditional-xor stages.
module crc8_step
    import crc8_pkg::*;
#(
    parameter logic [7:0] POLYNOMIAL = CRC8_POLY_DEFAULT
) (
    input  logic [7:0] crc_i,
    input  logic [7:0] data_i,
    output logic [7:0] crc_o
);

    logic [8:0][7:0] stage;

    assign stage[0] = crc_i ^ data_i;

    for (genvar i = 0; i < 8; i++) begin : g_stage
        assign stage[i+1] = stage[i][7] ? ({stage[i][6:0], 1'b0} ^ POLYNOMIAL)
                                        : {stage[i][6:0], 1'b0};
    end

    assign crc_o = stage[8];

endmodule

// File: rtl/crc8_checker.sv
// CRC-8 frame checker: strips the trailing CRC byte, forwards payload, reports pass/fail and length.
// Define CRC8_CHECKER_ERR_COUNT_EN to add a saturating failed-frame counter (err_count_o).
module crc8_checker
    import crc8_pkg::*;
#(
    parameter logic [7:0] POLYNOMIAL = CRC8_POLY_DEFAULT
) (
    input logic           clk_i,
    input logic           rst_i,
    crc8_checker_if.slave bus
);

    crc8_chk_state_t state_q, state_d;
    logic [7:0]  hold_q, hold_d;
    logic [7:0]  crc_q, crc_d;
    logic [15:0] len_q, len_d;
    logic [7:0]  data_q, data_d;
    logic        dvalid_q, dvalid_d;
    logic        dlast_q, dlast_d;
    logic        done_q, done_d;
    logic        ok_q, ok_d;
    logic        err_q, err_d;
    logic [15:0] length_q, length_d;
    logic [7:0]  crc_next;
    logic        crc_pass;

    crc8_step #(.POLYNOMIAL(POLYNOMIAL)) u_step (
        .crc_i (crc_q),
        .data_i(bus.data_i),
        .crc_o (crc_next)
    );

    // Residue over payload plus its CRC byte is zero for an intact frame.
    assign crc_pass = (crc_next == 8'h00);

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        crc_d    = crc_q;
        len_d    = len_q;
        data_d   = data_q;
        dvalid_d = 1'b0;
        dlast_d  = 1'b0;
        done_d   = 1'b0;
        ok_d     = ok_q;
        err_d    = err_q;
        length_d = length_q;

        if (bus.data_valid_i) begin
            case (state_q)
                IDLE: begin
                    if (bus.data_last_i) begin
                        done_d   = 1'b1;
                        length_d = 16'd0;
                        ok_d     = crc_pass;
                        err_d    = !crc_pass;
                        crc_d    = 8'h00;
                        len_d    = 16'd0;
                    end else begin
                        hold_d  = bus.data_i;
                        crc_d   = crc_next;
                        len_d   = 16'd0;
                        state_d = BODY;
                    end
                end
                BODY: begin
                    data_d   = hold_q;
                    dvalid_d = 1'b1;
                    if (bus.data_last_i) begin
                        dlast_d  = 1'b1;
                        done_d   = 1'b1;
                        length_d = sat_inc16(len_q);
                        ok_d     = crc_pass;
                        err_d    = !crc_pass;
                        crc_d    = 8'h00;
                        len_d    = 16'd0;
                        state_d  = IDLE;
                    end else begin
                        hold_d = bus.data_i;
                        crc_d  = crc_next;
                        len_d  = sat_inc16(len_q);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            hold_q   <= 8'h00;
            crc_q    <= 8'h00;
            len_q    <= 16'd0;
            data_q   <= 8'h00;
            dvalid_q <= 1'b0;
            dlast_q  <= 1'b0;
            done_q   <= 1'b0;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
            length_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            crc_q    <= crc_d;
            len_q    <= len_d;
            data_q   <= data_d;
            dvalid_q <= dvalid_d;
            dlast_q  <= dlast_d;
            done_q   <= done_d;
            ok_q     <= ok_d;
            err_q    <= err_d;
            length_q <= length_d;
        end
    end

    assign bus.data_o       = data_q;
    assign bus.data_valid_o = dvalid_q;
    assign bus.data_last_o  = dlast_q;
    assign bus.frame_done_o = done_q;
    assign bus.crc_ok_o     = ok_q;
    assign bus.crc_err_o    = err_q;
    assign bus.length_o     = length_q;

`ifdef CRC8_CHECKER_ERR_COUNT_EN
    logic [15:0] err_count_q, err_count_d;

    always_comb begin
        err_count_d = err_count_q;
        if (done_d && err_d) begin
            err_count_d = sat_inc16(err_count_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_count_q <= 16'd0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign bus.err_count_o = err_count_q;
`endif

endmodule

// File: tb/tb_crc8_checker.sv
// Scoreboard bench for crc8_checker: directed frames with hand-computed CRC results.
module tb_crc8_checker;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_data_t;

    typedef struct packed {
        logic        ok;
        logic [15:0] len;
        logic [15:0] errc;
    } exp_stat_t;

    logic clk_i = 1'b0;
    logic rst_i;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   errc = 0;

    exp_data_t exp_data[$];
    exp_stat_t exp_stat[$];
    int        done_cyc[$];

    crc8_checker_if bus ();

    crc8_checker dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus  (bus)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents payload or status.
    always @(negedge clk_i) begin
        if (bus.data_valid_o === 1'b1) begin
            if (exp_data.size() == 0) begin
                chk("unexpected_data_valid", bus.data_valid_o, 0);
            end else begin
                exp_data_t e;
                e = exp_data.pop_front();
                chk("data_o", bus.data_o, e.data);
                chk("data_last_o", bus.data_last_o, e.last);
            end
        end
        if (bus.frame_done_o === 1'b1) begin
            done_cyc.push_back(cyc);
            if (exp_stat.size() == 0) begin
                chk("unexpected_frame_done", bus.frame_done_o, 0);
            end else begin
                exp_stat_t s;
                s = exp_stat.pop_front();
                chk("crc_ok_o", bus.crc_ok_o, s.ok);
                chk("crc_err_o", bus.crc_err_o, !s.ok);
                chk("length_o", bus.length_o, s.len);
`ifdef CRC8_CHECKER_ERR_COUNT_EN
                chk("err_count_o", bus.err_count_o, s.errc);
`endif
            end
        end
    end

    task automatic send(input logic [7:0] b, input logic last);
        bus.data_i       = b;
        bus.data_valid_i = 1'b1;
        bus.data_last_i  = last;
        @(posedge clk_i);
        #1;
        bus.data_valid_i = 1'b0;
        bus.data_last_i  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic exp_byte(input logic [7:0] b, input logic last);
        exp_data.push_back('{data: b, last: last});
    endtask

    task automatic exp_frame(input logic ok, input int len);
        if (!ok) errc++;
        exp_stat.push_back('{ok: ok, len: 16'(len), errc: 16'(errc)});
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data_o"}, bus.data_o, 0);
        chk({tag, "_data_valid_o"}, bus.data_valid_o, 0);
        chk({tag, "_data_last_o"}, bus.data_last_o, 0);
        chk({tag, "_frame_done_o"}, bus.frame_done_o, 0);
        chk({tag, "_crc_ok_o"}, bus.crc_ok_o, 0);
        chk({tag, "_crc_err_o"}, bus.crc_err_o, 0);
        chk({tag, "_length_o"}, bus.length_o, 0);
`ifdef CRC8_CHECKER_ERR_COUNT_EN
        chk({tag, "_err_count_o"}, bus.err_count_o, 0);
`endif
    endtask

    initial begin
        rst_i            = 1'b1;
        bus.data_i       = 8'h00;
        bus.data_valid_i = 1'b0;
        bus.data_last_i  = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk_all_zero("reset");
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // last without valid must be ignored
        bus.data_last_i = 1'b1;
        idle(2);
        bus.data_last_i = 1'b0;

        // "123456789" with CRC 0xF4
        for (int i = 0; i < 9; i++) exp_byte(8'h31 + 8'(i), i == 8);
        exp_frame(1'b1, 9);
        for (int i = 0; i < 9; i++) send(8'h31 + 8'(i), 1'b0);
        send(8'hF4, 1'b1);
        idle(2);

        // 01,07 with a gap
        exp_byte(8'h01, 1'b1);
        exp_frame(1'b1, 1);
        send(8'h01, 1'b0);
        idle(3);
        send(8'h07, 1'b1);
        idle(2);

        // 01,08 -> bad CRC
        exp_byte(8'h01, 1'b1);
        exp_frame(1'b0, 1);
        send(8'h01, 1'b0);
        send(8'h08, 1'b1);
        idle(2);

        // zero-length frames
        exp_frame(1'b1, 0);
        send(8'h00, 1'b1);
        idle(2);
        exp_frame(1'b0, 0);
        send(8'h5A, 1'b1);
        idle(2);

        // back-to-back: ok then err, done pulses two cycles apart
        done_cyc.delete();
        exp_byte(8'h01, 1'b1);
        exp_frame(1'b1, 1);
        exp_byte(8'h01, 1'b1);
        exp_frame(1'b0, 1);
        send(8'h01, 1'b0);
        send(8'h07, 1'b1);
        send(8'h01, 1'b0);
        send(8'h08, 1'b1);
        idle(3);
        chk("b2b_done_count", done_cyc.size(), 2);
        if (done_cyc.size() == 2) chk("b2b_done_spacing", done_cyc[1] - done_cyc[0], 2);

        // reset after the 4th byte of a 9-byte frame
        exp_byte(8'h31, 1'b0);
        exp_byte(8'h32, 1'b0);
        exp_byte(8'h33, 1'b0);
        for (int i = 0; i < 4; i++) send(8'h31 + 8'(i), 1'b0);
        rst_i = 1'b1;
        errc  = 0;
        idle(2);
        @(negedge clk_i);
        chk_all_zero("midreset");
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        idle(3);
        exp_byte(8'h01, 1'b1);
        exp_frame(1'b1, 1);
        send(8'h01, 1'b0);
        send(8'h07, 1'b1);
        idle(4);

        chk("data_queue_drained", exp_data.size(), 0);
        chk("status_queue_drained", exp_stat.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/crc8_checker.md
# crc8_checker

Receive-side counterpart of the CRC-8 generator. Consumes a byte stream in which each frame ends with its CRC-8 byte, using the same static polynomial, zero initial value, no reflection and no final XOR. Forwards the payload with the CRC byte stripped, and reports pass/fail plus payload length once per frame. Sits between a byte-oriented receiver (UART/SPI deframer) and the packet consumer.

## Interface
- `POLYNOMIAL`, default 8'h07: CRC-8 generator polynomial, implicit x^8.
- `clk_i` in 1: clock.
- `rst_i` in 1: synchronous, active-high reset.
- `data_i` in 8: input byte.
- `data_valid_i` in 1: `data_i` valid this cycle; byte accepted. No backpressure.
- `data_last_i` in 1: qualified by `data_valid_i`; this byte is the frame's CRC byte.
- `data_o` out 8: payload byte out.
- `data_valid_o` out 1: `data_o` valid; one-cycle pulse per payload byte.
- `data_last_o` out 1: with `data_valid_o`; final payload byte of the frame.
- `frame_done_o` out 1: one-cycle pulse; status outputs are updated this cycle.
- `crc_ok_o` out 1: last completed frame passed.
- `crc_err_o` out 1: last completed frame failed. Always the inverse of `crc_ok_o` after the first frame.
- `length_o` out 16: payload byte count of the last completed frame. Saturates at 16'hFFFF.

## Operation
- Running CRC `crc_q` is updated on every accepted byte: `crc_q <= crc8_next(crc_q, data_i)`. Payload bytes and the CRC byte are both included.
  - The frame passes iff the CRC over the whole frame, including the CRC byte, equals 8'h00.
- FSM states:
  - IDLE: no byte of the current frame held.
  - BODY: one payload byte held in `hold_q`.
- IDLE, valid & !last:
  - Latch byte into `hold_q`.
  - `crc_q` = step(0, byte), `len_q` = 0.
  - Go to BODY.
- IDLE, valid & last (zero-length frame):
  - Next cycle: `frame_done_o`=1, `length_o`=0, `crc_ok_o` = (byte == 8'h00).
  - No `data_valid_o`.
  - Stay in IDLE; `crc_q` is cleared to 0.
- BODY, valid & !last:
  - Next cycle: `data_o` = old `hold_q`, `data_valid_o`=1, `data_last_o`=0.
  - `hold_q` <= byte; `len_q` += 1 (saturating).
- BODY, valid & last:
  - Next cycle: `data_o` = `hold_q`, `data_valid_o`=1, `data_last_o`=1, `frame_done_o`=1.
  - `length_o` = `len_q`+1 (saturating); `crc_ok_o` from the final CRC.
  - Go to IDLE; `crc_q` and `len_q` are cleared.
- BODY, !valid: hold everything. Gaps of any length are allowed.
- The CRC byte never appears on `data_o`.

## Timing
- All outputs are registered. Latency is one cycle after acceptance of the byte that releases them.
  - Payload byte N is emitted the cycle after byte N+1 is accepted.
  - The status update occurs the cycle after the CRC byte is accepted.
- Back-to-back frames are supported: a new frame's first byte may arrive the cycle after the previous `data_last_i`.
- Reset values:
  - `data_o`=0, `data_valid_o`=0, `data_last_o`=0, `frame_done_o`=0.
  - `crc_ok_o`=0, `crc_err_o`=0, `length_o`=0.
  - FSM=IDLE, `crc_q`=0, `len_q`=0, `hold_q`=0.
- Reset mid-frame discards the partial frame. No `frame_done_o` and no further `data_valid_o` for that frame.
- `data_last_i` without `data_valid_i` is ignored.
- `crc_ok_o`, `crc_err_o` and `length_o` hold their values between `frame_done_o` pulses.

## Configuration
- `CRC8_CHECKER_ERR_COUNT_EN` defined:
  - Adds output `err_count_o` [15:0]: count of failed frames.
  - Increments in the same cycle `crc_err_o` is set by a `frame_done_o`.
  - Saturates at 16'hFFFF; reset value 0.
- Macro undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Package `crc8_pkg`:
  - `crc8_next(crc, byte)` function, polynomial passed as an argument.
  - Default polynomial constant `CRC8_POLY_DEFAULT` = 8'h07.
  - FSM state typedef `crc8_chk_state_t` {IDLE, BODY}.
- One natural sub-module, `crc8_step`: a combinational single-byte CRC update (xor, then 8 shift/conditional-xor stages), parameterised by `POLYNOMIAL`. Shared with future CRC blocks.

## Test plan
- Frame "123456789" (8'h31–8'h39) then 8'hF4, contiguous:
  - 9 `data_valid_o` pulses 31..39, last flagged on 39.
  - `frame_done_o` with `crc_ok_o`=1, `length_o`=9.
- Frame 8'h01, 8'h07 with 3 idle cycles between → `data_o`=01 with `data_last_o`; ok, length 1.
- Frame 8'h01, 8'h08 → `crc_err_o`=1, `crc_ok_o`=0, length 1. With the macro: `err_count_o`=1.
- Single-byte frames:
  - 8'h00 → ok, length 0, no `data_valid_o`.
  - 8'h5A → err, length 0.
- Back-to-back frames 01,07 then 01,08 with no gap → two `frame_done_o` pulses two cycles apart: ok then err.
- Assert `rst_i` after the 4th byte of a 9-byte frame:
  - No further outputs; all outputs read 0.
  - The next frame 01,07 passes with length 1.
